// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory port between the instruction-fetch path (if_*) and the
//   load/store data path (d_*). A three-state controller (IDLE/MEM/RESP)
//   serialises accesses. It holds the downstream request stable until
//   mem_response, then returns read data and a one-cycle response pulse to
//   the granted requester.
//
//   Build option: MEM_ARB_ROUND_ROBIN_EN
//     defined   - on simultaneous requests, the port that lost the previous
//                 grant wins. Fetch is preferred after reset.
//     undefined - fixed priority: the data port always beats fetch.
//
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   if_addr/if_read_en              fetch request (held until if_response)
//   if_read_val/if_response         fetch data + one-cycle completion pulse
//   d_addr/d_read_en/d_write_en/d_write_val  data request (held until d_response)
//   d_read_val/d_response           load data + one-cycle completion pulse
//   mem_addr/mem_read_en/mem_write_en/mem_write_val  downstream request (level-held)
//   mem_read_val/mem_response       downstream read data + one-cycle completion
//   grant             owner of current/last transaction (0 fetch, 1 data)
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_read_en,
  output logic [DATA_W-1:0] if_read_val,
  output logic              if_response,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read_en,
  input  logic              d_write_en,
  input  logic [DATA_W-1:0] d_write_val,
  output logic [DATA_W-1:0] d_read_val,
  output logic              d_response,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_write_val,
  input  logic [DATA_W-1:0] mem_read_val,
  input  logic              mem_response,
  output logic              grant
);

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_RESP} state_t;

  state_t r_state;
  logic   w_d_req;
  logic   w_pick_d;

  // A data request is either direction; write takes precedence in IDLE.
  assign w_d_req = d_read_en | d_write_en;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // r_last_d: 1 when the data port won the last grant. The reset value of 1
  // makes fetch the preferred winner of the first contested grant.
  logic r_last_d;

  assign w_pick_d = w_d_req & (~if_read_en | ~r_last_d);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_last_d <= 1'b1;
    else if (r_state == S_IDLE && (w_d_req || if_read_en))
      r_last_d <= w_pick_d;
  end
`else
  assign w_pick_d = w_d_req;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      mem_addr      <= '0;
      mem_read_en   <= 1'b0;
      mem_write_en  <= 1'b0;
      mem_write_val <= '0;
      if_read_val   <= '0;
      if_response   <= 1'b0;
      d_read_val    <= '0;
      d_response    <= 1'b0;
      grant         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_d_req || if_read_en) begin
            if (w_pick_d) begin
              mem_addr      <= d_addr;
              mem_write_val <= d_write_val;
              mem_write_en  <= d_write_en;
              mem_read_en   <= ~d_write_en;
              grant         <= 1'b1;
            end else begin
              mem_addr     <= if_addr;
              mem_write_en <= 1'b0;
              mem_read_en  <= 1'b1;
              grant        <= 1'b0;
            end
            r_state <= S_MEM;
          end
        end
        S_MEM: begin
          if (mem_response) begin
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            if (grant) begin
              d_response <= 1'b1;
              if (mem_read_en)
                d_read_val <= mem_read_val;
            end else begin
              if_response <= 1'b1;
              if_read_val <= mem_read_val;
            end
            r_state <= S_RESP;
          end
        end
        // Requests are not sampled here, so a requester dropping its
        // enable after seeing the pulse is never re-granted.
        S_RESP: begin
          if_response <= 1'b0;
          d_response  <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_read_en = 1'b0;
  logic [DW-1:0] if_read_val;
  logic          if_response;
  logic [AW-1:0] d_addr = '0;
  logic          d_read_en = 1'b0;
  logic          d_write_en = 1'b0;
  logic [DW-1:0] d_write_val = '0;
  logic [DW-1:0] d_read_val;
  logic          d_response;
  logic [AW-1:0] mem_addr;
  logic          mem_read_en;
  logic          mem_write_en;
  logic [DW-1:0] mem_write_val;
  logic [DW-1:0] mem_read_val = '0;
  logic          mem_response = 1'b0;
  logic          grant;

  int n_tot = 0;
  int n_bad = 0;
  int n_acc = 0;
  logic prev_stb = 1'b0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .if_addr(if_addr), .if_read_en(if_read_en),
    .if_read_val(if_read_val), .if_response(if_response),
    .d_addr(d_addr), .d_read_en(d_read_en), .d_write_en(d_write_en),
    .d_write_val(d_write_val), .d_read_val(d_read_val), .d_response(d_response),
    .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_write_val(mem_write_val), .mem_read_val(mem_read_val),
    .mem_response(mem_response), .grant(grant)
  );

  always #5 clk = ~clk;

  // Counts downstream accesses (strobe rising) sampled mid-cycle.
  always @(negedge clk) begin
    if ((mem_read_en | mem_write_en) && !prev_stb) n_acc++;
    prev_stb = mem_read_en | mem_write_en;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    while (!(mem_read_en | mem_write_en) && n < 20) begin
      tick();
      n++;
    end
  endtask

  // Waits for a grant, checks owner/address, answers with zero wait and
  // checks that only the owner's response pulses. Returns at the response cycle.
  task automatic txn(input string tag, input logic eg, input logic [31:0] ea,
                     input logic [31:0] rd);
    int n;
    wait_strobe(n);
    chk({tag, "_strb"}, 64'(mem_read_en | mem_write_en), 64'd1);
    chk({tag, "_grant"}, 64'(grant), 64'(eg));
    chk({tag, "_addr"}, 64'(mem_addr), 64'(ea));
    mem_response = 1'b1;
    mem_read_val = rd;
    tick();
    mem_response = 1'b0;
    chk({tag, "_dresp"}, 64'(d_response), 64'(eg));
    chk({tag, "_iresp"}, 64'(if_response), 64'(!eg));
  endtask

  initial begin
    int n;
    int base;
    logic eg;

    // reset state
    repeat (2) tick();
    chk("rst_rd", 64'(mem_read_en), 64'd0);
    chk("rst_wr", 64'(mem_write_en), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wval", 64'(mem_write_val), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_resp", 64'({if_response, d_response}), 64'd0);
    chk("rst_rvals", 64'({if_read_val, d_read_val}), 64'd0);
    reset = 1'b1;
    tick();

    // fetch only, 3-cycle memory
    if_addr = 32'h100; if_read_en = 1'b1;
    tick();
    chk("f_rd0", 64'(mem_read_en), 64'd1);
    chk("f_wr0", 64'(mem_write_en), 64'd0);
    chk("f_addr", 64'(mem_addr), 64'h100);
    chk("f_grant", 64'(grant), 64'd0);
    tick();
    chk("f_rd1", 64'(mem_read_en), 64'd1);
    tick();
    chk("f_rd2", 64'(mem_read_en), 64'd1);
    chk("f_noresp", 64'(if_response), 64'd0);
    mem_response = 1'b1; mem_read_val = 32'hDEADBEEF;
    tick();
    mem_response = 1'b0; mem_read_val = '0; if_read_en = 1'b0;
    chk("f_resp", 64'(if_response), 64'd1);
    chk("f_rval", 64'(if_read_val), 64'hDEADBEEF);
    chk("f_rd_off", 64'(mem_read_en), 64'd0);
    chk("f_dresp", 64'(d_response), 64'd0);
    tick();
    chk("f_resp_end", 64'(if_response), 64'd0);
    chk("f_rval_hold", 64'(if_read_val), 64'hDEADBEEF);
    tick();
    chk("f_noregrant", 64'(mem_read_en | mem_write_en), 64'd0);

    // store, zero-wait
    d_addr = 32'h200; d_write_val = 32'h12345678; d_write_en = 1'b1;
    tick();
    chk("s_wr", 64'(mem_write_en), 64'd1);
    chk("s_rd", 64'(mem_read_en), 64'd0);
    chk("s_addr", 64'(mem_addr), 64'h200);
    chk("s_wval", 64'(mem_write_val), 64'h12345678);
    chk("s_grant", 64'(grant), 64'd1);
    mem_response = 1'b1; mem_read_val = 32'hBAD0BAD0;
    tick();
    mem_response = 1'b0; d_write_en = 1'b0;
    chk("s_resp", 64'(d_response), 64'd1);
    chk("s_wr_off", 64'(mem_write_en), 64'd0);
    chk("s_rval", 64'(d_read_val), 64'd0);
    tick();
    chk("s_resp_end", 64'(d_response), 64'd0);

    // read and write both high: write wins
    d_addr = 32'h300; d_write_val = 32'hA5A5A5A5; d_read_en = 1'b1; d_write_en = 1'b1;
    tick();
    chk("rw_wr", 64'(mem_write_en), 64'd1);
    chk("rw_rd", 64'(mem_read_en), 64'd0);
    mem_response = 1'b1; mem_read_val = 32'hFFFFFFFF;
    tick();
    mem_response = 1'b0; d_read_en = 1'b0; d_write_en = 1'b0;
    chk("rw_resp", 64'(d_response), 64'd1);
    chk("rw_rval", 64'(d_read_val), 64'd0);
    tick();

    // simultaneous fetch/load held across repeats, from a fresh reset
    reset = 1'b0; tick(); reset = 1'b1; tick();
    if_addr = 32'h10; if_read_en = 1'b1;
    d_addr = 32'h20; d_read_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      eg = (k % 2) == 1;
`else
      eg = 1'b1;
`endif
      txn($sformatf("sim%0d", k), eg, eg ? 32'h20 : 32'h10, 32'hC0DE0000 + k);
      if (k == 3) begin if_read_en = 1'b0; d_read_en = 1'b0; end
      if (eg) chk($sformatf("sim%0d_dval", k), 64'(d_read_val), 64'(32'hC0DE0000 + k));
      else    chk($sformatf("sim%0d_ival", k), 64'(if_read_val), 64'(32'hC0DE0000 + k));
    end
    tick(); tick();
    chk("sim_idle", 64'(mem_read_en | mem_write_en), 64'd0);

    // reset during MEM with a slow memory
    d_addr = 32'h400; d_read_en = 1'b1;
    tick();
    chk("r_rd", 64'(mem_read_en), 64'd1);
    tick(); tick();
    #2 reset = 1'b0;
    #1;
    chk("r_async_rd", 64'(mem_read_en), 64'd0);
    chk("r_async_addr", 64'(mem_addr), 64'd0);
    d_read_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    mem_response = 1'b1; mem_read_val = 32'h99999999;
    tick();
    mem_response = 1'b0;
    chk("r_late_resp", 64'({d_response, if_response}), 64'd0);
    chk("r_late_strb", 64'(mem_read_en | mem_write_en), 64'd0);
    tick();
    chk("r_late_resp2", 64'({d_response, if_response}), 64'd0);
    chk("r_dval", 64'(d_read_val), 64'd0);
    // IDLE takes a new request on the very next edge
    if_addr = 32'h500; if_read_en = 1'b1;
    tick();
    chk("r_idle_rd", 64'(mem_read_en), 64'd1);
    chk("r_idle_addr", 64'(mem_addr), 64'h500);
    mem_response = 1'b1; mem_read_val = 32'h55;
    tick();
    mem_response = 1'b0; if_read_en = 1'b0;
    chk("r_idle_resp", 64'(if_response), 64'd1);
    tick(); tick();

    // back-to-back fetches, request dropped the cycle after the response
    base = n_acc;
    if_addr = 32'h600; if_read_en = 1'b1;
    txn("bb0", 1'b0, 32'h600, 32'h0600AAAA);
    chk("bb0_val", 64'(if_read_val), 64'h0600AAAA);
    tick();
    if_read_en = 1'b0;
    tick();
    chk("bb_noregrant", 64'(mem_read_en | mem_write_en), 64'd0);
    if_addr = 32'h604; if_read_en = 1'b1;
    wait_strobe(n);
    chk("bb1_gap", 64'(n), 64'd1);
    chk("bb1_addr", 64'(mem_addr), 64'h604);
    mem_response = 1'b1; mem_read_val = 32'h0604BBBB;
    tick();
    mem_response = 1'b0;
    chk("bb1_resp", 64'(if_response), 64'd1);
    chk("bb1_val", 64'(if_read_val), 64'h0604BBBB);
    tick();
    if_read_en = 1'b0;
    tick(); tick();
    chk("bb_accesses", 64'(n_acc - base), 64'd2);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
